if_buf_writer: RTL

- Write-side controller for the input-feature (IF) circular scratchpad.
- Accepts a streamed input frame over a valid/ready handshake and writes it into the buffer at a wrapping address.
- Tracks complete rows, start pointer and end pointer; presents valid_IF to the convolution read controller.
- Frees buffer space when the reader releases its oldest row. It is the producer for the IF reader.

---
 rtl/if_buf_pkg.sv | 27 ++
 rtl/if_buf_ptr.sv | 33 +++
 rtl/if_buf_writer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_buf_pkg.sv
// Shared definitions for the IF buffer writer: state encoding, depth derivation
// and the wrapping pointer-advance helper.
package if_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        INIT  = 2'b01,
        FILL  = 2'b10,
        DRAIN = 2'b11
    } wr_state_t;

    localparam int PTR_W_MAX = 16;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Wide operands so one helper serves any ADDR_W up to PTR_W_MAX; callers cast back.
    function automatic logic [PTR_W_MAX-1:0] ptr_adv(input logic [PTR_W_MAX-1:0] ptr,
                                                     input logic [PTR_W_MAX-1:0] inc,
                                                     input int                   addr_w);
        logic [PTR_W_MAX-1:0] mask;
        mask = PTR_W_MAX'((32'd1 << addr_w) - 32'd1);
        return (ptr + inc) & mask;
    endfunction

endpackage

// File: rtl/if_buf_ptr.sv
// Write pointer, start pointer and occupancy count of the IF circular buffer.
// Accept and release may land in the same cycle; both take effect.
module if_buf_ptr
    import if_buf_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic              rel,
    input  logic [ADDR_W:0]   rl,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] start_ptr,
    output logic [ADDR_W:0]   count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr      <= '0;
            start_ptr <= '0;
            count     <= '0;
        end else begin
            if (adv)
                wptr <= ADDR_W'(ptr_adv(PTR_W_MAX'(wptr), PTR_W_MAX'(1), ADDR_W));
            if (rel)
                start_ptr <= ADDR_W'(ptr_adv(PTR_W_MAX'(start_ptr), PTR_W_MAX'(rl), ADDR_W));
            count <= count + (ADDR_W+1)'(adv) - (rel ? rl : (ADDR_W+1)'(0));
        end
    end

endmodule

// File: rtl/if_buf_writer.sv
// Write-side controller for the IF circular scratchpad: streams a frame in, tracks rows.
// Optional protocol checking on err is enabled by defining IF_WR_PROTO_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | one cycle: clear pointers, counters and row tracking
// FILL  | accepting stream words into the buffer
// DRAIN | frame written; waiting for the reader to release remaining rows
module if_buf_writer
    import if_buf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   row_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              rd_release,
    output logic              buf_wen,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic [ADDR_W-1:0] start_ptr,
    output logic [ADDR_W-1:0] end_ptr,
    output logic              valid_IF,
    output logic              done,
    output logic              err
);

    localparam int              DEPTH   = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    wr_state_t         state, state_nxt;
    logic [ADDR_W:0]   rl, col_cnt, rows_avail, rows_nxt, count;
    logic [ADDR_W-1:0] wptr;
    logic              accept, row_done, rel_ok, clr, done_nxt, rl_oor;

    assign rl_oor   = (row_len == '0) || (row_len > DEPTH_V);
    assign clr      = (state == INIT);
    assign in_ready = (state == FILL) && (count < DEPTH_V);
    assign accept   = in_valid && in_ready;
    assign row_done = accept && (col_cnt == (rl - (ADDR_W+1)'(1)));
    assign rel_ok   = rd_release && (rows_avail != '0);
    assign rows_nxt = rows_avail + (ADDR_W+1)'(row_done) - (ADDR_W+1)'(rel_ok);

    assign buf_wen   = accept;
    assign buf_waddr = wptr;
    assign buf_wdata = in_data;
    assign valid_IF  = (rows_avail != '0);

    if_buf_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .adv       (accept),
        .rel       (rel_ok),
        .rl        (rl),
        .wptr      (wptr),
        .start_ptr (start_ptr),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = INIT;
            INIT:  state_nxt = FILL;
            FILL:  if (accept && in_last) state_nxt = DRAIN;
            DRAIN: if (rows_nxt == '0) begin
                       done_nxt  = 1'b1;
                       state_nxt = IDLE;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    // Row length is captured with start so INIT sees a stable, clamped value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rl         <= DEPTH_V;
            col_cnt    <= '0;
            rows_avail <= '0;
            end_ptr    <= '0;
            done       <= 1'b0;
        end else begin
            done <= done_nxt;
            if (state == IDLE && start)
                rl <= rl_oor ? DEPTH_V : row_len;
            if (clr) begin
                col_cnt    <= '0;
                rows_avail <= '0;
                end_ptr    <= '0;
            end else begin
                rows_avail <= rows_nxt;
                if (row_done) begin
                    col_cnt <= '0;
                    end_ptr <= wptr;
                end else if (accept) begin
                    col_cnt <= col_cnt + (ADDR_W+1)'(1);
                end
            end
        end
    end

`ifdef IF_WR_PROTO_CHECK_EN
    logic rl_bad, err_q, proto_ev;

    assign proto_ev = (accept && in_last && !row_done) || (rd_release && rows_avail == '0);
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rl_bad <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && start)
                rl_bad <= rl_oor;
            if (clr)
                err_q <= rl_bad | proto_ev;
            else if (proto_ev)
                err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
